// File: rtl/fetch_stage_if.sv
// Fetch-stage boundary: hazard/redirect controls coming in, fetch address,
// IF/ID control and performance counters going out.
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  StallF;
  logic                  PCSrcE;
  logic [DATA_WIDTH-1:0] PCTargetE;
  logic                  HaltD;
  logic [DATA_WIDTH-1:0] PCF;
  logic [DATA_WIDTH-1:0] PC_PlusF;
  logic                  FlushD;
  logic                  ValidF;
  logic                  Halted;
  logic [DATA_WIDTH-1:0] FetchCount;
  logic [DATA_WIDTH-1:0] RedirectCount;

  // The fetch stage itself.
  modport master (
    input  StallF, PCSrcE, PCTargetE, HaltD,
    output PCF, PC_PlusF, FlushD, ValidF, Halted, FetchCount, RedirectCount
  );

  // The pipeline around it (hazard unit, execute, IF/ID register, perf bench).
  modport slave (
    output StallF, PCSrcE, PCTargetE, HaltD,
    input  PCF, PC_PlusF, FlushD, ValidF, Halted, FetchCount, RedirectCount
  );
endinterface

// File: rtl/fetch_stage.sv
// Program-counter owner for the fetch stage: boot delay, stall hold,
// execute redirect, terminal halt, plus fetch/redirect counters.
module fetch_stage #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'hBFC00000,
  parameter int                    BOOT_CYCLES  = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master fif
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [3:0]            BOOT_INIT = 4'(BOOT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] PC_STEP   = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] CNT_ONE   = DATA_WIDTH'(1);

  state_t                state_q, state_d;
  logic [3:0]            boot_cnt_q, boot_cnt_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [DATA_WIDTH-1:0] redirect_cnt_q, redirect_cnt_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational processes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= BOOT;
      boot_cnt_q     <= BOOT_INIT;
      pc_q           <= RESET_VECTOR;
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      boot_cnt_q     <= boot_cnt_d;
      pc_q           <= pc_d;
      fetch_cnt_q    <= fetch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a hold default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    boot_cnt_d     = boot_cnt_q;
    pc_d           = pc_q;
    fetch_cnt_d    = fetch_cnt_q;
    redirect_cnt_d = redirect_cnt_q;

    unique case (state_q)
      BOOT: begin
        if (boot_cnt_q == 4'd0) state_d = RUN;
        else                    boot_cnt_d = boot_cnt_q - 4'd1;
      end
      RUN: begin
        // Redirect beats stall and halt: anything younger is wrong-path.
        if (fif.PCSrcE) begin
          pc_d           = fif.PCTargetE;
          redirect_cnt_d = redirect_cnt_q + CNT_ONE;
        end else if (fif.StallF) begin
          pc_d = pc_q;
        end else if (fif.HaltD) begin
          state_d = HALTED;
        end else begin
          pc_d        = pc_q + PC_STEP;
          fetch_cnt_d = fetch_cnt_q + CNT_ONE;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    fif.PCF           = pc_q;
    fif.PC_PlusF      = pc_q + PC_STEP;
    fif.FetchCount    = fetch_cnt_q;
    fif.RedirectCount = redirect_cnt_q;
    fif.ValidF        = 1'b0;
    fif.FlushD        = 1'b1;
    fif.Halted        = 1'b0;

    unique case (state_q)
      RUN: begin
        fif.ValidF = 1'b1;
        // Same-cycle flush lets IF/ID drop the wrong-path word on the
        // edge that loads the redirect target or enters halt.
        fif.FlushD = fif.PCSrcE | (~fif.StallF & fif.HaltD);
      end
      HALTED:  fif.Halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Fetch-side producer for the IF/ID pipeline register. Owns the program counter, drives the instruction-memory address and the PC / PC+4 values latched into decode, and generates the decode flush. Handles reset boot delay, stall hold, execute-stage branch/jump redirect and a terminal halt. Also keeps fetch and redirect counters for the performance testbench.

## Interface
- DATA_WIDTH, 32, width of PC and counters
- RESET_VECTOR, 32'hBFC00000, PC loaded on reset
- BOOT_CYCLES, 2, cycles after reset before fetching starts; legal range 1..15
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; synchronous, active-high; one clock, with synchronous active-high reset
- StallF  in  1  hazard-unit stall; high = hold PC
- PCSrcE  in  1  execute-stage redirect request (taken branch / jump)
- PCTargetE  in  DATA_WIDTH  redirect target address
- HaltD  in  1  decode reports a halt instruction
- PCF  out  DATA_WIDTH  current fetch address, to instruction memory and IF/ID register
- PC_PlusF  out  DATA_WIDTH  PCF + 4
- FlushD  out  1  clear request to IF/ID register
- ValidF  out  1  current PCF is a real fetch
- Halted  out  1  fetch has stopped permanently
- FetchCount  out  DATA_WIDTH  instructions advanced past fetch
- RedirectCount  out  DATA_WIDTH  redirects accepted

## Operation
- States: BOOT, RUN, HALTED. Down-counter boot_cnt, 4 bits.
- Reset: state=BOOT, boot_cnt=BOOT_CYCLES-1, PCF=RESET_VECTOR, FetchCount=0, RedirectCount=0. Reset dominates all other inputs.
- BOOT: PCF held; ValidF=0; FlushD=1; all inputs ignored. boot_cnt decrements each cycle. When boot_cnt==0, go to RUN next cycle.
- RUN, priority high to low:
  - Redirect: PCSrcE=1. Next PCF=PCTargetE, used verbatim with no alignment change. FlushD=1 in this cycle. RedirectCount+1. StallF and HaltD are ignored.
  - Stall: StallF=1. PCF held; no count change; HaltD ignored.
  - Halt: HaltD=1. Go to HALTED; PCF held; FlushD=1 in this cycle.
  - Advance: next PCF=PC_PlusF; FetchCount+1.
- HALTED: PCF frozen; FlushD=1; ValidF=0; Halted=1. PCSrcE, StallF and HaltD are ignored. Only rst exits this state.
- ValidF=1 only in RUN.
- FlushD is 0 in RUN except on a redirect or halt cycle.
- Arithmetic:
  - PC_PlusF = PCF + 4, modulo 2^DATA_WIDTH, so 0xFFFFFFFC+4 = 0.
  - Both counters wrap modulo 2^DATA_WIDTH with no saturation.

## Timing
- PCF, state, boot_cnt, counters and Halted are registered; each changes only on the rising edge after its cause.
- PC_PlusF, ValidF and FlushD are combinational from state and the current inputs. This lets the IF/ID register clear on the same edge that PCF takes the redirect target.
- Redirect latency: PCSrcE high in cycle n gives PCF=PCTargetE in cycle n+1. The wrong-path instruction in IF/ID is cleared at the cycle-n edge.
- First real fetch: ValidF rises BOOT_CYCLES cycles after rst falls, with PCF=RESET_VECTOR.
- Simultaneous events:
  - PCSrcE+StallF: redirect wins.
  - PCSrcE+HaltD: redirect wins and no halt occurs, because the halt is on the wrong path.
  - StallF+HaltD: stall wins and the halt is re-evaluated next cycle.
- rst asserted in any state, including mid-redirect or HALTED, returns to reset values at the next edge.

## Test plan
- Boot: rst for 1 cycle, then idle. ValidF=0 and FlushD=1 for 2 cycles with PCF=0xBFC00000. Then ValidF=1 and PCF steps 0xBFC00004, 0xBFC00008. FetchCount=2 after two RUN cycles.
- Stall: in RUN at PCF=0xBFC00010, StallF=1 for 3 cycles. PCF, PC_PlusF=0xBFC00014 and FetchCount are unchanged; FlushD=0; advance resumes after release.
- Redirect: PCSrcE=1, PCTargetE=0xBFC00100 for one cycle. FlushD=1 that cycle, next PCF=0xBFC00100, RedirectCount=1. Repeat with StallF=1 in the same cycle: same result.
- Halt: HaltD=1 at PCF=0xBFC00020. Next cycle Halted=1, PCF=0xBFC00020, FlushD=1. PCSrcE pulses are ignored afterwards; rst restores PCF=0xBFC00000 and state BOOT.
- Conflicts: HaltD+PCSrcE gives a redirect with Halted=0. HaltD+StallF gives no halt that cycle; Halted=1 arrives one cycle after StallF drops.
- Wrap: redirect to 0xFFFFFFFC. PC_PlusF=0x00000000 and next PCF=0x00000000. Preload FetchCount to 0xFFFFFFFF via force; one advance gives 0.
